// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory-stage load/store unit.
//
// Takes the M-stage control/data of a pipelined RV32I core and runs one
// word-wide ready/ack data-memory transaction per load or store. It steers
// store bytes onto their lanes and extracts and extends load data. The
// pipeline is held while the bus is busy. Misaligned or illegal accesses
// and accesses the bus never answers are flagged.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   MemWriteM, ResultSrcM    store / load (ResultSrcM == 2'b01) markers
//   Funct3M                  access size and signedness
//   ALUResultM               effective byte address
//   WriteDataM               store data
//   ReadDataM                extended load result (registered)
//   StallM                   hold the F/D/E/M pipeline registers
//   MisalignM, TimeoutM      one-cycle fault pulses (registered)
//   mem_req/we/addr/be/wdata registered bus request
//   mem_ack, mem_rdata       bus completion and read data
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        TimeoutM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter holds 0..MAX_WAIT-1; the last REQ cycle is the one at LAST_CNT.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        is_load_r;
  logic [2:0]  f3_r;
  logic [1:0]  addr_lo_r;

  logic        is_store_s;
  logic        is_load_s;
  logic        access_s;
  logic        fault_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  // Access is illegal for reserved sizes or when not naturally aligned.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lo);
    logic f;
    case (f3)
      3'b000, 3'b100: f = 1'b0;
      3'b001, 3'b101: f = lo[0];
      3'b010:         f = (lo != 2'b00);
      default:        f = 1'b1;
    endcase
    return f;
  endfunction

  // Store byte enables for the addressed lanes.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane select plus sign/zero extension of a read word.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*lo +: 8];
    h = rd[16*lo[1] +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Decode the M-stage request; a simultaneous load/store is a store.
  always_comb begin
    is_store_s = MemWriteM;
    is_load_s  = ~MemWriteM & (ResultSrcM == 2'b01);
    access_s   = is_store_s | is_load_s;
    fault_s    = access_fault(Funct3M, ALUResultM[1:0]);
    if (is_store_s) begin
      be_s    = store_be(Funct3M, ALUResultM[1:0]);
      wdata_s = store_data(Funct3M, WriteDataM);
    end else begin
      be_s    = 4'b1111;
      wdata_s = 32'd0;
    end
  end

  // Stall from the first IDLE cycle of a valid access through REQ; DONE releases.
  always_comb begin
    case (state_r)
      ST_IDLE: StallM = access_s & ~fault_s;
      ST_REQ:  StallM = 1'b1;
      ST_DONE: StallM = 1'b0;
      default: StallM = 1'b0;
    endcase
  end

  // Access FSM with registered bus outputs, load result and fault pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      is_load_r <= 1'b0;
      f3_r      <= 3'd0;
      addr_lo_r <= 2'd0;
      ReadDataM <= 32'd0;
      MisalignM <= 1'b0;
      TimeoutM  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      MisalignM <= 1'b0;
      TimeoutM  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (access_s && fault_s) begin
            MisalignM <= 1'b1;
          end else if (access_s) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store_s;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_be    <= be_s;
            mem_wdata <= wdata_s;
            is_load_r <= is_load_s;
            f3_r      <= Funct3M;
            addr_lo_r <= ALUResultM[1:0];
            cnt_r     <= 8'd0;
            state_r   <= ST_REQ;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load_r) begin
              ReadDataM <= load_extend(f3_r, addr_lo_r, mem_rdata);
            end else begin
              ReadDataM <= ReadDataM;
            end
            state_r <= ST_DONE;
          end else if (cnt_r == LAST_CNT) begin
            mem_req  <= 1'b0;
            TimeoutM <= 1'b1;
            if (is_load_r) begin
              ReadDataM <= 32'd0;
            end else begin
              ReadDataM <= ReadDataM;
            end
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        TimeoutM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_lsu #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .TimeoutM(TimeoutM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    MemWriteM  = we;
    ResultSrcM = rs;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    #1;
  endtask

  task automatic idle_in();
    drv(1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    idle_in();
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rd", ReadDataM, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_mis", {31'd0, MisalignM}, 32'd0);
    chk("rst_to", {31'd0, TimeoutM}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);

    // 1: LB 0x1003, ack in first REQ cycle
    drv(1'b0, 2'b01, 3'b000, 32'h0000_1003, 32'd0);
    chk("t1_stall_idle", {31'd0, StallM}, 32'd1);
    cyc();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h0000_1000);
    chk("t1_be", {28'd0, mem_be}, 32'h0000_000F);
    chk("t1_we", {31'd0, mem_we}, 32'd0);
    chk("t1_stall_req", {31'd0, StallM}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    cyc();
    mem_ack = 1'b0;
    chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t1_rd", ReadDataM, 32'hFFFF_FF80);
    chk("t1_stall_done", {31'd0, StallM}, 32'd0);
    idle_in();
    cyc();
    chk("t1_stall_idle2", {31'd0, StallM}, 32'd0);

    // 2: SH 0x2002, ack in third REQ cycle
    drv(1'b1, 2'b00, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
    chk("t2_stall0", {31'd0, StallM}, 32'd1);
    cyc();
    chk("t2_we", {31'd0, mem_we}, 32'd1);
    chk("t2_be", {28'd0, mem_be}, 32'h0000_000C);
    chk("t2_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("t2_addr", mem_addr, 32'h0000_2000);
    chk("t2_stall1", {31'd0, StallM}, 32'd1);
    cyc();
    chk("t2_stall2", {31'd0, StallM}, 32'd1);
    chk("t2_req2", {31'd0, mem_req}, 32'd1);
    cyc();
    chk("t2_stall3", {31'd0, StallM}, 32'd1);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("t2_stall_done", {31'd0, StallM}, 32'd0);
    chk("t2_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t2_rd_kept", ReadDataM, 32'hFFFF_FF80);
    idle_in();
    cyc();

    // 3: misaligned LW, then illegal Funct3M
    drv(1'b0, 2'b01, 3'b010, 32'h0000_3001, 32'd0);
    chk("t3a_stall", {31'd0, StallM}, 32'd0);
    cyc();
    chk("t3a_mis", {31'd0, MisalignM}, 32'd1);
    chk("t3a_req", {31'd0, mem_req}, 32'd0);
    idle_in();
    chk("t3a_stall2", {31'd0, StallM}, 32'd0);
    cyc();
    chk("t3a_mis_end", {31'd0, MisalignM}, 32'd0);
    drv(1'b0, 2'b01, 3'b011, 32'h0000_3000, 32'd0);
    chk("t3b_stall", {31'd0, StallM}, 32'd0);
    cyc();
    chk("t3b_mis", {31'd0, MisalignM}, 32'd1);
    chk("t3b_req", {31'd0, mem_req}, 32'd0);
    idle_in();
    cyc();
    chk("t3b_mis_end", {31'd0, MisalignM}, 32'd0);
    chk("t3_rd_kept", ReadDataM, 32'hFFFF_FF80);

    // 4: LHU 0x4002 never acked -> timeout after 15 REQ cycles
    drv(1'b0, 2'b01, 3'b101, 32'h0000_4002, 32'd0);
    cyc();
    chk("t4_req1", {31'd0, mem_req}, 32'd1);
    for (int i = 2; i <= 15; i++) begin
      cyc();
      chk("t4_req_hold", {31'd0, mem_req}, 32'd1);
      chk("t4_stall_hold", {31'd0, StallM}, 32'd1);
    end
    cyc();
    chk("t4_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t4_to", {31'd0, TimeoutM}, 32'd1);
    chk("t4_rd", ReadDataM, 32'd0);
    chk("t4_stall_done", {31'd0, StallM}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    idle_in();
    cyc();
    chk("t4_to_end", {31'd0, TimeoutM}, 32'd0);
    cyc();
    mem_ack = 1'b0;
    chk("t4_late_rd", ReadDataM, 32'd0);
    chk("t4_late_req", {31'd0, mem_req}, 32'd0);
    chk("t4_late_stall", {31'd0, StallM}, 32'd0);

    // 5: SW 0x10 then LBU 0x11, both acked immediately
    drv(1'b1, 2'b01, 3'b010, 32'h0000_0010, 32'h1122_3344);
    cyc();
    chk("t5_sw_we", {31'd0, mem_we}, 32'd1);
    chk("t5_sw_be", {28'd0, mem_be}, 32'h0000_000F);
    chk("t5_sw_wd", mem_wdata, 32'h1122_3344);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("t5_sw_done", {31'd0, StallM}, 32'd0);
    chk("t5_sw_rd", ReadDataM, 32'd0);
    drv(1'b0, 2'b01, 3'b100, 32'h0000_0011, 32'd0);
    chk("t5_done_stall", {31'd0, StallM}, 32'd0);
    chk("t5_done_req", {31'd0, mem_req}, 32'd0);
    cyc();
    chk("t5_lbu_idle_stall", {31'd0, StallM}, 32'd1);
    cyc();
    chk("t5_lbu_req", {31'd0, mem_req}, 32'd1);
    chk("t5_lbu_addr", mem_addr, 32'h0000_0010);
    chk("t5_lbu_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_AB00;
    cyc();
    mem_ack = 1'b0;
    chk("t5_lbu_rd", ReadDataM, 32'h0000_00AB);
    idle_in();
    cyc();

    // Extra lanes: SB 0x5001 and LH 0x6002 sign extension
    drv(1'b1, 2'b00, 3'b000, 32'h0000_5001, 32'h0000_00A5);
    cyc();
    chk("sb_be", {28'd0, mem_be}, 32'h0000_0002);
    chk("sb_wd", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    drv(1'b0, 2'b01, 3'b001, 32'h0000_6002, 32'd0);
    cyc();
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
    cyc();
    mem_ack = 1'b0;
    chk("lh_rd", ReadDataM, 32'hFFFF_8001);
    idle_in();
    cyc();

    // 6: reset during REQ with a simultaneous ack
    drv(1'b0, 2'b01, 3'b010, 32'h0000_0020, 32'd0);
    cyc();
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cyc();
    rst = 1'b0; mem_ack = 1'b0;
    idle_in();
    chk("t6_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rd", ReadDataM, 32'd0);
    chk("t6_stall", {31'd0, StallM}, 32'd0);
    chk("t6_be", {28'd0, mem_be}, 32'd0);
    cyc();
    chk("t6_stall2", {31'd0, StallM}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
